// File: rtl/convertidor_binario_desde_bcd.sv
// convertidor_binario_desde_bcd
//   Sequential BCD-to-binary converter (reverse double-dabble), one iteration
//   per clock. A packed BCD value {centenas,decenas,unidades} is latched on an
//   accepted start and converted to binary with start/busy/valid handshaking.
//
// Ports
//   clk       in   1          rising-edge clock
//   rst_n     in   1          asynchronous active-low reset
//   start     in   1          conversion request, only honoured while idle
//   decimal   in   4*DIGITS   packed BCD input, digit 0 in bits [3:0]
//   dato      out  OUT_W      binary result, held until the next result
//   valid     out  1          one-cycle pulse when dato/overflow/error update
//   busy      out  1          high from accepted start until the valid cycle
//   overflow  out  1          value did not fit in OUT_W bits, dato saturated
//   error     out  1          input had a digit above 9, dato forced to 0
module convertidor_binario_desde_bcd #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   decimal,
  output logic [OUT_W-1:0]      dato,
  output logic                  valid,
  output logic                  busy,
  output logic                  overflow,
  output logic                  error
);

  localparam int ITER  = $clog2(10**DIGITS);
  localparam int SW    = 4*DIGITS + ITER;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int CW    = (ITER > OUT_W) ? ITER : OUT_W;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SW-1:0]    sreg;
  logic [CNT_W-1:0] cnt;
  logic             err_pend;
  logic             bad_in;
  logic [OUT_W:0]   sat_res;

  // True when any BCD digit of the input is outside 0..9.
  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // After the right shift every BCD digit that reads 8 or more held a
  // borrowed "ten" from the digit above; subtracting 3 restores it to a
  // proper base-10 digit. Digits are corrected independently.
  function automatic logic [SW-1:0] adjust(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[ITER + 4*i +: 4] >= 4'd8)
        r[ITER + 4*i +: 4] = r[ITER + 4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  // Saturating truncation of the ITER-bit result into OUT_W bits.
  // Returns {overflow, value}.
  function automatic logic [OUT_W:0] saturate(input logic [ITER-1:0] b);
    logic [CW-1:0] ext;
    logic [CW-1:0] lim;
    ext = CW'(b);
    lim = CW'({OUT_W{1'b1}});
    if (ext > lim) return {1'b1, {OUT_W{1'b1}}};
    return {1'b0, ext[OUT_W-1:0]};
  endfunction

  assign bad_in  = has_bad_digit(decimal);
  assign sat_res = saturate(sreg[ITER-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = bad_in ? DONE : CONV;
      CONV: if (cnt == CNT_W'(ITER - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      dato     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      error    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (bad_in) begin
              err_pend <= 1'b1;
            end else begin
              err_pend <= 1'b0;
              sreg     <= {decimal, {ITER{1'b0}}};
              cnt      <= '0;
            end
          end
        end
        CONV: begin
          sreg <= adjust(sreg >> 1);
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
          valid    <= 1'b1;
          busy     <= 1'b0;
          err_pend <= 1'b0;
          if (err_pend) begin
            dato     <= '0;
            overflow <= 1'b0;
            error    <= 1'b1;
          end else begin
            dato     <= sat_res[OUT_W-1:0];
            overflow <= sat_res[OUT_W];
            error    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_convertidor_binario_desde_bcd.sv
// tb_convertidor_binario_desde_bcd
//   Drives two instances (OUT_W=8 and OUT_W=10) of the BCD-to-binary
//   converter with directed and random BCD values and compares every result
//   against a decimal-arithmetic reference model.
module tb_convertidor_binario_desde_bcd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] decimal;
  logic [7:0]  dato;
  logic        valid;
  logic        busy;
  logic        overflow;
  logic        error;
  logic [9:0]  dato10;
  logic        valid10;
  logic        busy10;
  logic        overflow10;
  logic        error10;

  int checks = 0;
  int errors = 0;

  convertidor_binario_desde_bcd #(.DIGITS(3), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decimal(decimal),
    .dato(dato), .valid(valid), .busy(busy), .overflow(overflow), .error(error)
  );

  convertidor_binario_desde_bcd #(.DIGITS(3), .OUT_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .decimal(decimal),
    .dato(dato10), .valid(valid10), .busy(busy10), .overflow(overflow10),
    .error(error10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: interpret the digits as a decimal number.
  task automatic model(input logic [11:0] d, output int val, output bit bad);
    logic [3:0] dig;
    int weight;
    val = 0;
    bad = 0;
    weight = 1;
    for (int i = 0; i < 3; i++) begin
      dig = d[4*i +: 4];
      if (dig > 9) bad = 1;
      val += int'(dig) * weight;
      weight *= 10;
    end
  endtask

  // Issue one conversion from idle and check latency, busy and results.
  task automatic run(input logic [11:0] d, input string tag);
    int val;
    bit bad;
    int lat;
    bit seen;
    bit busy_ok;
    int exp_dato;
    logic [7:0] held;
    model(d, val, bad);
    exp_dato = bad ? 0 : ((val > 255) ? 255 : val);
    decimal = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    decimal = 12'($urandom);
    lat = 0;
    seen = 0;
    busy_ok = 1;
    while (!seen && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 0;
      @(posedge clk); #1;
      lat++;
      if (valid === 1'b1) seen = 1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), bad ? 32'd1 : 32'd11);
    chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_at_valid"}, 32'(busy), 32'd0);
    chk({tag, "_dato"}, 32'(dato), 32'(exp_dato));
    chk({tag, "_ovf"}, 32'(overflow), 32'((!bad && val > 255) ? 1 : 0));
    chk({tag, "_err"}, 32'(error), 32'(bad ? 1 : 0));
    chk({tag, "_dato10"}, 32'(dato10), bad ? 32'd0 : 32'(val));
    chk({tag, "_ovf10"}, 32'(overflow10), 32'd0);
    held = dato;
    @(posedge clk); #1;
    chk({tag, "_valid_pulse"}, 32'(valid), 32'd0);
    chk({tag, "_dato_hold"}, 32'(dato), 32'(held));
  endtask

  initial begin
    int nvalid;
    logic [7:0] got;
    logic [11:0] rd;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    decimal = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dato", 32'(dato), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_flags", 32'({overflow, error}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(12'h255, "t1_255");
    run(12'h000, "t2_000");
    run(12'h999, "t3_999");
    run(12'h1A3, "t4_err");
    run(12'h001, "after_err");

    // Start held and re-pulsed while busy: exactly one result.
    decimal = 12'h042;
    start = 1'b1;
    @(posedge clk); #1;
    nvalid = 0;
    got = 8'h00;
    for (int c = 1; c <= 25; c++) begin
      if (c == 6) start = 1'b0;
      if (c == 7) begin start = 1'b1; decimal = 12'h777; end
      if (c == 8) start = 1'b0;
      @(posedge clk); #1;
      if (valid === 1'b1) begin nvalid++; got = dato; end
    end
    chk("t5_valid_count", 32'(nvalid), 32'd1);
    chk("t5_dato", 32'(got), 32'd42);

    // Reset in the middle of a conversion aborts it.
    decimal = 12'h128;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_dato", 32'(dato), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) seen = 1;
    end
    chk("t6_no_valid", 32'(seen), 32'd0);
    run(12'h128, "t6_restart");

    // Boundaries around the 8-bit limit.
    run(12'h256, "edge_256");
    run(12'h099, "edge_099");
    run(12'h90F, "edge_bad_unit");

    // Random values, mostly legal BCD with occasional illegal digits.
    for (int n = 0; n < 40; n++) begin
      rd = 12'h000;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 9) == 0) rd[4*i +: 4] = 4'($urandom_range(10, 15));
        else                          rd[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      run(rd, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
